axi_rd_responder: RTL and testbench
===================================

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 13, meaning word-address width; 2^13 words = 32 KiB backing store.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port araddr, input, 15, meaning the byte address of the first beat.
REQ-005 SHALL have port arburst, input, 2, meaning burst type: 00 FIXED, 01 INCR, others unsupported.
REQ-006 SHALL have ports arcache (4), arlock (1), arprot (3) and arqos (4), all inputs, all accepted and ignored.
REQ-007 SHALL have port arid, input, 4, meaning the transaction ID.
REQ-008 SHALL have port arlen, input, 8, meaning beats minus 1.
REQ-009 SHALL have port arsize, input, 3, meaning beat size; only 010 (4 bytes) is supported.
REQ-010 SHALL have ports arvalid (input, 1) and arready (output, 1), meaning the AR handshake.
REQ-011 SHALL have port rdata, output, 32, meaning the read beat data.
REQ-012 SHALL have port rid, output, 4, meaning the echoed arid.
REQ-013 SHALL have ports rresp (output, 2) and rlast (output, 1), meaning the beat response and the final-beat flag.
REQ-014 SHALL have ports rvalid (output, 1) and rready (input, 1), meaning the R handshake.
REQ-015 SHALL have ports mem_en (output, 1) and mem_addr (output, DEPTH_LOG2), meaning the synchronous-RAM read request, word-addressed.
REQ-016 SHALL have port mem_dout, input, 32, meaning RAM read data, valid exactly one cycle after mem_en.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, CAPTURE and RESP.
REQ-018 SHALL drive arready=1 only in IDLE; an AR handshake (arvalid&&arready) latches address, arid, arlen, arburst and the error flag, then moves to FETCH.
REQ-019 SHALL in FETCH assert mem_en for exactly one cycle with mem_addr=addr[DEPTH_LOG2+1:2], then move to CAPTURE.
REQ-020 SHALL in CAPTURE register mem_dout into rdata (or 0 on error), set rvalid=1 and rlast=(beat==arlen), then move to RESP.
REQ-021 SHALL in RESP hold rdata, rid, rresp and rlast stable while rvalid=1 and rready=0.
REQ-022 SHALL on an R handshake clear rvalid; if rlast, go to IDLE; else increment the beat counter, update the address and go to FETCH.
REQ-023 SHALL, for the address update, leave the address unchanged for FIXED; INCR adds 4 modulo 2^15 (0x7FFC+4 wraps to 0x0000).
REQ-024 SHALL treat arburst in {10, 11} or arsize != 010 as an error: still return arlen+1 beats, with rresp=10 (SLVERR), rdata=0 and mem_en kept low.
REQ-025 SHALL otherwise return rresp=00 (OKAY); araddr[1:0] is ignored.
REQ-026 SHALL have AR-handshake-to-first-rvalid latency of 3 cycles (FETCH, CAPTURE, RESP) and 3 cycles per beat thereafter with rready held high.
REQ-027 SHALL accept arlen=0 as a single beat with rlast=1; arlen=255 yields 256 beats, the 8-bit beat counter never overflows.
REQ-028 SHALL ignore arvalid outside IDLE (arready=0); exactly one transaction is outstanding.
REQ-029 SHALL allow an AR handshake in the cycle immediately after the final R handshake.

Reset
REQ-030 SHALL on rstn=0 asynchronously set state=IDLE, arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_en=0, mem_addr=0 and beat counter=0.
REQ-031 SHALL drive arready=1 from the first clock edge after rstn deasserts.
REQ-032 SHALL abandon any in-flight burst on reset mid-operation, with no further beats issued.

Structure
REQ-033 SHALL keep burst encodings (FIXED/INCR), rresp encodings (OKAY/SLVERR), the supported arsize and the FSM state enum in the shared axi package, reused by fetch-side masters.
REQ-034 SHALL be a single module with no sub-modules; the RAM is external, attached through mem_*.

Verification
REQ-035 SHALL cover: araddr=0x0010, arlen=0, INCR, arid=5, RAM[4]=0xDEADBEEF -> one beat rdata=0xDEADBEEF, rid=5, rlast=1, rresp=00, rvalid 3 cycles after AR.
REQ-036 SHALL cover: araddr=0x7FF8, arlen=3, INCR -> mem_addr 0x1FFE, 0x1FFF, 0x0000, 0x0001; rlast only on beat 4.
REQ-037 SHALL cover: FIXED, arlen=2, araddr=0x0020 -> three beats all from mem_addr 0x0008.
REQ-038 SHALL cover: rready low for 5 cycles mid-burst -> rdata/rid/rlast stable, rvalid held, no mem_en pulse.
REQ-039 SHALL cover: arburst=10, arlen=1 -> two beats, rresp=10, rdata=0, mem_en never asserted.
REQ-040 SHALL cover: rstn pulsed during beat 2 of 4 -> rvalid=0 immediately, arready=1 after release, next AR served normally.

Source files
------------

// File: rtl/axi_rd_responder_pkg.sv
// rtl/axi_rd_responder_pkg.sv - shared AXI read encodings, FSM states and helpers
package axi_rd_responder_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Anything other than FIXED/INCR with 4-byte beats is answered with SLVERR.
    function automatic logic is_unsupported(input logic [1:0] burst, input logic [2:0] size);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != SIZE_4B);
    endfunction

endpackage

// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - single-outstanding AXI read responder over an external sync RAM
module axi_rd_responder
    import axi_rd_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 13
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [1:0]            arburst,
    input  logic [3:0]            arcache,
    input  logic                  arlock,
    input  logic [2:0]            arprot,
    input  logic [3:0]            arqos,
    input  logic [ID_W-1:0]       arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [ID_W-1:0]       rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_en,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_dout
);

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_q;
    logic [1:0]          burst_q;
    logic                err_q;
    logic                ar_hs;
    logic                r_hs;
    logic                unused_ok;

    assign unused_ok = ^{arcache, arlock, arprot, arqos, araddr[1:0]};

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (r_hs) state_d = rlast ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Error bursts still walk the FSM but never touch the RAM.
    assign mem_en   = (state_q == FETCH) && !err_q;
    assign mem_addr = addr_q[DEPTH_LOG2+1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rdata   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= BURST_FIXED;
            err_q   <= 1'b0;
        end else begin
            // Registered so it stays low in reset and rises on the first edge after release.
            arready <= (state_d == IDLE);

            if (state_q == IDLE && ar_hs) begin
                addr_q  <= araddr;
                rid     <= arid;
                len_q   <= arlen;
                burst_q <= arburst;
                err_q   <= is_unsupported(arburst, arsize);
                beat_q  <= '0;
            end

            if (state_q == CAPTURE) begin
                rdata  <= err_q ? '0 : mem_dout;
                rresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
                rlast  <= (beat_q == len_q);
                rvalid <= 1'b1;
            end

            if (state_q == RESP && r_hs) begin
                rvalid <= 1'b0;
                if (!rlast) begin
                    beat_q <= beat_q + 8'd1;
                    if (burst_q == BURST_INCR) begin
                        addr_q <= addr_q + ADDR_W'(4);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - randomized self-checking bench for axi_rd_responder
module tb_axi_rd_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [14:0] araddr = '0;
    logic [1:0]  arburst = '0;
    logic [3:0]  arcache = '0;
    logic        arlock = 1'b0;
    logic [2:0]  arprot = '0;
    logic [3:0]  arqos = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        mem_en;
    logic [12:0] mem_addr;
    logic [31:0] mem_dout = '0;

    logic [31:0] ram [0:8191];
    int checks = 0;
    int failures = 0;

    logic [14:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    logic [2:0]  rs;
    logic [3:0]  ri;
    int          rsel;

    axi_rd_responder #(.DEPTH_LOG2(13)) dut (
        .clk(clk), .rstn(rstn),
        .araddr(araddr), .arburst(arburst), .arcache(arcache), .arlock(arlock),
        .arprot(arprot), .arqos(arqos), .arid(arid), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_dout <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: rready high, latency checked; 1: random rready plus junk arvalid; 2: 5-cycle stall on beat 2
    task automatic run_txn(input logic [14:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int mode, input int rst_beat);
        logic        err;
        int          beats;
        int          mem_seen;
        int          cyc;
        int          stall;
        logic [14:0] ea;
        logic [31:0] ed;
        logic [1:0]  er;

        err   = !(burst == 2'b00 || burst == 2'b01) || (size != 3'b010);
        beats = int'(len) + 1;
        er    = err ? 2'b10 : 2'b00;

        @(negedge clk);
        araddr = a; arlen = len; arburst = burst; arsize = size; arid = id;
        arcache = 4'($urandom); arlock = 1'($urandom); arprot = 3'($urandom); arqos = 4'($urandom);
        arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        araddr = 15'($urandom); arid = 4'($urandom); arlen = 8'($urandom);
        arvalid = (mode == 1) ? 1'($urandom) : 1'b0;
        cyc = 1;
        mem_seen = 0;

        for (int i = 0; i < beats; i++) begin
            ea = (burst == 2'b01) ? a + 15'(4 * i) : a;
            ed = err ? 32'd0 : ram[ea[14:2]];
            while (!rvalid && cyc < 50) begin
                if (mem_en) begin
                    check("mem_addr", 32'(mem_addr), 32'(ea[14:2]));
                    mem_seen++;
                end
                @(negedge clk);
                cyc++;
            end
            if (!rvalid) begin
                check("rvalid_timeout", 32'd0, 32'd1);
                arvalid = 1'b0;
                return;
            end
            if (mode == 0) check("latency", 32'(cyc), 32'd3);
            if (rst_beat == i) begin
                rstn = 1'b0;
                #1;
                check("rst_rvalid", 32'(rvalid), 32'd0);
                check("rst_arready", 32'(arready), 32'd0);
                check("rst_mem_en", 32'(mem_en), 32'd0);
                check("rst_rdata", rdata, 32'd0);
                check("rst_rlast", 32'(rlast), 32'd0);
                @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                check("rst_arready_rel", 32'(arready), 32'd1);
                repeat (4) begin
                    @(negedge clk);
                    check("rst_no_beat", 32'({rvalid, mem_en}), 32'd0);
                end
                return;
            end
            check("mem_en_in_resp", 32'(mem_en), 32'd0);
            check("rdata", rdata, ed);
            check("rid", 32'(rid), 32'(id));
            check("rresp", 32'(rresp), 32'(er));
            check("rlast", 32'(rlast), 32'(i == beats - 1));
            stall = (mode == 2 && i == 1) ? 5 : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
            repeat (stall) begin
                rready = 1'b0;
                @(negedge clk);
                check("hold_rvalid", 32'(rvalid), 32'd1);
                check("hold_rdata", rdata, ed);
                check("hold_rid", 32'(rid), 32'(id));
                check("hold_rlast", 32'(rlast), 32'(i == beats - 1));
                check("hold_rresp", 32'(rresp), 32'(er));
                check("hold_mem_en", 32'(mem_en), 32'd0);
                check("arready_busy", 32'(arready), 32'd0);
            end
            rready = 1'b1;
            if (i == beats - 1) arvalid = 1'b0;
            @(negedge clk);
            cyc = 1;
            check("rvalid_clr", 32'(rvalid), 32'd0);
            if (mode == 1) rready = 1'($urandom);
        end
        check("arready_after", 32'(arready), 32'd1);
        check("mem_en_count", 32'(mem_seen), err ? 32'd0 : 32'(beats));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8192; k++) ram[k] = $urandom;
        ram[4] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check("reset_arready", 32'(arready), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rlast", 32'(rlast), 32'd0);
        check("reset_rresp", 32'(rresp), 32'd0);
        check("reset_rid", 32'(rid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("arready_after_reset", 32'(arready), 32'd1);

        run_txn(15'h0010, 8'd0, 2'b01, 3'b010, 4'd5, 0, -1);
        check("single_beat_data", ram[4], 32'hDEADBEEF);
        run_txn(15'h7FF8, 8'd3, 2'b01, 3'b010, 4'd2, 0, -1);
        run_txn(15'h0020, 8'd2, 2'b00, 3'b010, 4'd7, 0, -1);
        run_txn(15'h0100, 8'd3, 2'b01, 3'b010, 4'd9, 2, -1);
        run_txn(15'h0040, 8'd1, 2'b10, 3'b010, 4'd3, 0, -1);
        run_txn(15'h0044, 8'd2, 2'b01, 3'b011, 4'd4, 0, -1);
        run_txn(15'h0200, 8'd3, 2'b01, 3'b010, 4'd6, 0, 1);
        run_txn(15'h0300, 8'd1, 2'b01, 3'b010, 4'd8, 0, -1);

        for (int t = 0; t < 20; t++) begin
            ra   = 15'($urandom);
            rl   = (t == 5) ? 8'd255 : 8'($urandom_range(0, 7));
            rsel = int'($urandom_range(0, 9));
            rb   = (rsel < 4) ? 2'b00 : (rsel < 8) ? 2'b01 : (rsel == 8) ? 2'b10 : 2'b11;
            rs   = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
            ri   = 4'($urandom);
            run_txn(ra, rl, rb, rs, ri, t % 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
